cwbp_ptr_fetch_queue: RTL and testbench
=======================================

Name: cwbp_ptr_fetch_queue

Overview:
- Parametrised successor to the single-pointer base-address reader feeding the CWBP decoder.
- Burst-reads a whole patch of CWBP mapping pointers from the base-address BRAM and decodes each into Way/Row.
- Buffers the decoded descriptors in a FIFO and hands them to the AXI flash-command master over a valid/ready stream.
- Counts patches per frame, replacing the fixed 2-bit patch counter; its frame-finish pulse feeds the Water-S logic.

Parameters:
- START_ADDR, 32'h4580_0000, byte address of pointer 0 of patch 0 in BRAM.
- DATA_WIDTH, 32, mapping-pointer width.
- WAY_WIDTH, 4, Way field width (pointer MSBs).
- ENTRY_NUM, 16, pointers per patch (>=1).
- FIFO_DEPTH, 8, descriptor FIFO depth (power of 2, >=2).
- PATCH_NUM, 2, patches per frame (>=1).
- NUM_WAYS, 8, populated ways; used only with CWBP_WAY_CHECK_EN.

Ports:
- clk  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to fetch the next patch
- ram_addr  out  32  BRAM byte address
- ram_en  out  1  BRAM read enable
- ram_rd_data  in  DATA_WIDTH  BRAM read data, valid 1 cycle after ram_en
- desc_valid  out  1  descriptor available
- desc_ready  in  1  consumer accepts descriptor
- desc_way  out  WAY_WIDTH  decoded Way
- desc_row  out  DATA_WIDTH-WAY_WIDTH  decoded Row_address
- desc_last  out  1  descriptor is the last one of the patch
- busy  out  1  fetch or drain in progress
- patch_idx  out  clog2(PATCH_NUM) (min 1)  current patch number
- patch_done  out  1  one-cycle pulse at patch completion
- frame_finish  out  1  one-cycle pulse when the last patch of the frame completes
- way_err  out  1  sticky bad-Way flag

Behaviour:
- Reset (async assert, sync deassert) values: ram_en=0, ram_addr=START_ADDR, desc_valid=0, desc_last=0, busy=0, patch_idx=0, patch_done=0, frame_finish=0, way_err=0. FIFO is empty and the FSM is in IDLE.
- Reset asserted mid-operation aborts everything: FIFO is flushed, in-flight read is discarded, no pulses are emitted.
- Decode: desc_way = ptr[DATA_WIDTH-1 -: WAY_WIDTH]; desc_row = ptr[DATA_WIDTH-WAY_WIDTH-1:0].
- IDLE: start=1 -> FETCH, busy=1, issue counter i=0. start is ignored in every state other than IDLE.
- FETCH: ram_en=1 when credit = FIFO_DEPTH - occupancy - inflight > 0, otherwise ram_en=0 (stall).
  - ram_addr = START_ADDR + 4*(patch_idx*ENTRY_NUM + i), computed mod 2^32.
  - i increments on each issue.
  - Data returning one cycle later is decoded and pushed. The push for entry ENTRY_NUM-1 carries last=1.
  - After issue ENTRY_NUM-1 -> DRAIN.
- The FIFO never overflows: credit accounting guarantees this, so no full-drop path exists. Simultaneous push and pop in one cycle keeps occupancy unchanged.
- Output is FIFO-head registered: desc_* are stable while desc_valid=1 and desc_ready=0. Pop occurs on desc_valid&desc_ready.
- Throughput: 1 descriptor/cycle sustained when desc_ready is held at 1. First desc_valid appears 2 cycles after start.
- DRAIN: when the last=1 descriptor is popped -> DONE.
- DONE (1 cycle):
  - patch_done=1 and busy=0.
  - If patch_idx==PATCH_NUM-1: frame_finish=1 and patch_idx wraps to 0; else patch_idx+1.
  - Then -> IDLE.
- start arriving in the DONE cycle is ignored.

Optional Feature:
- Macro: CWBP_WAY_CHECK_EN.
- Defined: any pushed pointer with Way >= NUM_WAYS sets way_err=1, which holds until reset. The descriptor is still queued unchanged.
- Undefined: way_err is tied 0 and no comparator is built.

Test Plan:
- ENTRY_NUM=4, BRAM[i]=32'h3000_0010+i, desc_ready=1, start pulse -> ram_addr 0x4580_0000..0x4580_000C; desc_way=3; rows 0x10..0x13; desc_last on 4th; patch_done 1 cycle after last pop; patch_idx=1.
- FIFO_DEPTH=2, ENTRY_NUM=6, desc_ready=0 for 20 cycles -> exactly 2 ram_en issued; desc_valid=1 with head held; releasing desc_ready gives all 6 in order with no loss or duplicate.
- PATCH_NUM=2, two back-to-back patches -> second patch reads from 0x4580_0000+4*ENTRY_NUM; frame_finish pulses once, with the 2nd patch_done; patch_idx returns to 0.
- start pulsed during FETCH/DRAIN and in the DONE cycle -> ignored; exactly one patch fetched.
- rst_n low for 1 cycle mid-FETCH with 3 entries queued -> all outputs at reset values; desc_valid=0; next start refetches patch 0 from START_ADDR.
- CWBP_WAY_CHECK_EN defined, NUM_WAYS=8, pointer 32'h9000_0001 -> descriptor delivered with way=9; way_err rises and holds through later valid entries. Macro undefined -> way_err stays 0.

Source files
------------

// File: rtl/cwbp_ptr_fetch_queue.sv
// -----------------------------------------------------------------------------
// cwbp_ptr_fetch_queue
//
// Purpose:
//   Burst-reads one patch of CWBP mapping pointers (ENTRY_NUM words) from the
//   base-address BRAM, decodes each pointer into Way/Row, buffers the
//   descriptors in a small FIFO and hands them to the flash-command master
//   over a valid/ready stream. Counts patches per frame and pulses
//   frame_finish when the last patch of a frame completes.
//
// Optional build macro:
//   CWBP_WAY_CHECK_EN - when defined, any pointer whose Way >= NUM_WAYS sets
//                       the sticky way_err flag (descriptor still queued).
//                       When undefined, way_err is tied low.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             single-cycle request to fetch the next patch (IDLE only)
//   ram_addr/ram_en   BRAM byte address / read enable
//   ram_rd_data       BRAM read data, valid one cycle after ram_en
//   desc_*            descriptor stream (valid/ready, way, row, last)
//   busy              fetch or drain in progress
//   patch_idx         current patch number within the frame
//   patch_done        one-cycle pulse when a patch has fully drained
//   frame_finish      one-cycle pulse with the last patch_done of a frame
//   way_err           sticky bad-Way flag
//   dbg_state         current FSM state (IDLE=0, FETCH=1, DRAIN=2, DONE=3)
//
// Handshake: a descriptor transfers on any cycle where desc_valid and
// desc_ready are both high; while desc_valid=1 and desc_ready=0 all desc_*
// outputs hold steady, and desc_valid never drops without a transfer.
// -----------------------------------------------------------------------------
module cwbp_ptr_fetch_queue #(
  parameter logic [31:0] START_ADDR = 32'h4580_0000,
  parameter int DATA_WIDTH = 32,
  parameter int WAY_WIDTH  = 4,
  parameter int ENTRY_NUM  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PATCH_NUM  = 2,
  parameter int NUM_WAYS   = 8
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              start,
  output logic [31:0]                                       ram_addr,
  output logic                                              ram_en,
  input  logic [DATA_WIDTH-1:0]                             ram_rd_data,
  output logic                                              desc_valid,
  input  logic                                              desc_ready,
  output logic [WAY_WIDTH-1:0]                              desc_way,
  output logic [DATA_WIDTH-WAY_WIDTH-1:0]                   desc_row,
  output logic                                              desc_last,
  output logic                                              busy,
  output logic [((PATCH_NUM > 1) ? $clog2(PATCH_NUM) : 1)-1:0] patch_idx,
  output logic                                              patch_done,
  output logic                                              frame_finish,
  output logic                                              way_err,
  output logic [1:0]                                        dbg_state
);

  localparam int PW = (PATCH_NUM > 1) ? $clog2(PATCH_NUM) : 1;
  localparam int IW = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = DATA_WIDTH - WAY_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] issue_q, issue_d;
  logic [PW-1:0] patch_idx_q, patch_idx_d;
  logic          inflight_q;       // a BRAM read was issued last cycle
  logic          inflight_last_q;  // ... and it was the last entry of the patch

  // Descriptor FIFO
  logic [WAY_WIDTH-1:0] fifo_way_q  [FIFO_DEPTH];
  logic [RW-1:0]        fifo_row_q  [FIFO_DEPTH];
  logic                 fifo_last_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;

  logic push, pop, issue_ok;
  logic [CW:0] occ_sum;

  assign push = inflight_q;
  assign pop  = (count_q != '0) && desc_ready;

  // Credit: issue only if the FIFO can absorb this read plus the one still
  // in flight. A pop in the same cycle frees a slot, which is what lets a
  // depth-2 FIFO sustain one descriptor per cycle.
  assign occ_sum  = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign issue_ok = occ_sum < ((CW+1)'(FIFO_DEPTH) + (CW+1)'(pop));

  always_comb begin
    state_d      = state_q;
    issue_d      = issue_q;
    patch_idx_d  = patch_idx_q;
    ram_en       = 1'b0;
    busy         = 1'b0;
    patch_done   = 1'b0;
    frame_finish = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          issue_d = '0;
        end
      end
      S_FETCH: begin
        busy = 1'b1;
        if (issue_ok) begin
          ram_en = 1'b1;
          if (issue_q == IW'(ENTRY_NUM - 1)) state_d = S_DRAIN;
          else                               issue_d = issue_q + 1'b1;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (pop && fifo_last_q[rd_ptr_q]) state_d = S_DONE;
      end
      S_DONE: begin
        patch_done = 1'b1;
        if (patch_idx_q == PW'(PATCH_NUM - 1)) begin
          frame_finish = 1'b1;
          patch_idx_d  = '0;
        end else begin
          patch_idx_d  = patch_idx_q + 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address wraps modulo 2^32 by construction of the 32-bit sum.
  assign ram_addr = START_ADDR +
                    ((32'(patch_idx_q) * 32'(ENTRY_NUM) + 32'(issue_q)) << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      issue_q         <= '0;
      patch_idx_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      issue_q         <= issue_d;
      patch_idx_q     <= patch_idx_d;
      inflight_q      <= ram_en;
      inflight_last_q <= ram_en && (issue_q == IW'(ENTRY_NUM - 1));
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // FIFO storage carries no reset; entries are only visible when count_q != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_way_q[wr_ptr_q]  <= ram_rd_data[DATA_WIDTH-1 -: WAY_WIDTH];
      fifo_row_q[wr_ptr_q]  <= ram_rd_data[RW-1:0];
      fifo_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

  assign desc_valid = (count_q != '0);
  assign desc_way   = fifo_way_q[rd_ptr_q];
  assign desc_row   = fifo_row_q[rd_ptr_q];
  assign desc_last  = desc_valid & fifo_last_q[rd_ptr_q];
  assign patch_idx  = patch_idx_q;
  assign dbg_state  = state_q;

`ifdef CWBP_WAY_CHECK_EN
  logic way_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      way_err_q <= 1'b0;
    end else if (push &&
                 (32'(ram_rd_data[DATA_WIDTH-1 -: WAY_WIDTH]) >= 32'(NUM_WAYS))) begin
      way_err_q <= 1'b1;
    end
  end
  assign way_err = way_err_q;
`else
  assign way_err = 1'b0;
`endif

endmodule

// File: tb/tb_cwbp_ptr_fetch_queue.sv
// -----------------------------------------------------------------------------
// Testbench for cwbp_ptr_fetch_queue (ENTRY_NUM=4, FIFO_DEPTH=2, PATCH_NUM=2).
// A BRAM model answers reads one cycle after ram_en; expected addresses and
// descriptors are queued when a patch is requested and popped by a negedge
// monitor as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_cwbp_ptr_fetch_queue;

  localparam int DW = 32;
  localparam int WW = 4;
  localparam int EN = 4;
  localparam int FD = 2;
  localparam int PN = 2;
  localparam int NW = 8;
  localparam logic [31:0] SA = 32'h4580_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start;
  logic [31:0]   ram_addr;
  logic          ram_en;
  logic [DW-1:0] ram_rd_data;
  logic          desc_valid;
  logic          desc_ready;
  logic [WW-1:0] desc_way;
  logic [DW-WW-1:0] desc_row;
  logic          desc_last;
  logic          busy;
  logic [0:0]    patch_idx;
  logic          patch_done;
  logic          frame_finish;
  logic          way_err;
  logic [1:0]    dbg_state;

  cwbp_ptr_fetch_queue #(
    .START_ADDR (SA),
    .DATA_WIDTH (DW),
    .WAY_WIDTH  (WW),
    .ENTRY_NUM  (EN),
    .FIFO_DEPTH (FD),
    .PATCH_NUM  (PN),
    .NUM_WAYS   (NW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ram_addr     (ram_addr),
    .ram_en       (ram_en),
    .ram_rd_data  (ram_rd_data),
    .desc_valid   (desc_valid),
    .desc_ready   (desc_ready),
    .desc_way     (desc_way),
    .desc_row     (desc_row),
    .desc_last    (desc_last),
    .busy         (busy),
    .patch_idx    (patch_idx),
    .patch_done   (patch_done),
    .frame_finish (frame_finish),
    .way_err      (way_err),
    .dbg_state    (dbg_state)
  );

  // BRAM model
  logic [DW-1:0] bram [EN*PN];
  always @(posedge clk) begin
    if (ram_en) begin
      int idx;
      idx = int'((ram_addr - SA) >> 2);
      if (idx >= 0 && idx < EN*PN) ram_rd_data <= bram[idx];
      else                         ram_rd_data <= 32'hDEAD_BEEF;
    end
  end

  // scoreboard
  logic [DW:0]   exp_q[$];       // {last, pointer}
  logic [31:0]   exp_addr_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int frame_cnt = 0;
  int last_pop_cyc = -10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_patch(input int p);
    for (int k = 0; k < EN; k++) begin
      exp_addr_q.push_back(SA + 32'(4 * (p * EN + k)));
      exp_q.push_back({(k == EN - 1), bram[p * EN + k]});
    end
  endtask

  // drive from #1 after a posedge; returns #1 after the next posedge
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    n0 = done_cnt;
    for (int k = 0; k < budget && done_cnt == n0; k++) @(posedge clk);
    #1;
    check("done_seen", 64'(done_cnt), 64'(n0 + 1));
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_en) begin
        en_cnt++;
        if (exp_addr_q.size() == 0) check("ram_en_unexpected", 64'(ram_en), 64'(0));
        else                        check("ram_addr", 64'(ram_addr), 64'(exp_addr_q.pop_front()));
      end
      if (desc_valid && desc_ready) begin
        if (exp_q.size() == 0) begin
          check("desc_unexpected", 64'(desc_valid), 64'(0));
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("desc_way",  64'(desc_way),  64'(e[DW-1 -: WW]));
          check("desc_row",  64'(desc_row),  64'(e[DW-WW-1:0]));
          check("desc_last", 64'(desc_last), 64'(e[DW]));
        end
        if (desc_last) last_pop_cyc = cyc;
      end
      if (patch_done) begin
        done_cnt++;
        check("done_after_last_pop", 64'(cyc), 64'(last_pop_cyc + 1));
        check("done_busy_low", 64'(busy), 64'(0));
      end
      if (frame_finish) begin
        frame_cnt++;
        check("frame_with_done", 64'(patch_done), 64'(1));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // directed sequence
  initial begin
    int first_cyc, en0, en1, k;
    logic [DW:0] head;
    logic exp_we;

    rst_n = 1'b0;
    start = 1'b0;
    desc_ready = 1'b0;
    for (int i = 0; i < EN; i++) bram[i] = 32'h3000_0010 + 32'(i);
    for (int i = EN; i < EN*PN; i++)
      bram[i] = {1'b0, 3'($urandom_range(0, 7)), 28'($urandom)};
    bram[EN + 1] = 32'h9000_0001;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_en",       64'(ram_en),       64'(0));
    check("rst_ram_addr",     64'(ram_addr),     64'(SA));
    check("rst_desc_valid",   64'(desc_valid),   64'(0));
    check("rst_desc_last",    64'(desc_last),    64'(0));
    check("rst_busy",         64'(busy),         64'(0));
    check("rst_patch_idx",    64'(patch_idx),    64'(0));
    check("rst_patch_done",   64'(patch_done),   64'(0));
    check("rst_frame_finish", 64'(frame_finish), 64'(0));
    check("rst_way_err",      64'(way_err),      64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // A: patch 0, consumer always ready, latency and throughput
    desc_ready = 1'b1;
    expect_patch(0);
    pulse_start();
    check("a_busy",   64'(busy),       64'(1));
    check("a_lat0",   64'(desc_valid), 64'(0));
    @(posedge clk); #1;
    check("a_lat1",   64'(desc_valid), 64'(0));
    @(posedge clk); #1;
    check("a_lat2",   64'(desc_valid), 64'(1));
    first_cyc = cyc;
    wait_done(30);
    check("a_patch_idx",  64'(patch_idx), 64'(1));
    check("a_throughput", 64'(last_pop_cyc - first_cyc), 64'(EN - 1));
    check("a_frame_cnt",  64'(frame_cnt), 64'(0));

    // R: reset mid-fetch of patch 1 with the FIFO full
    desc_ready = 1'b0;
    expect_patch(1);
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    check("r_valid_before", 64'(desc_valid), 64'(1));
    check("r_busy_before",  64'(busy),       64'(1));
    rst_n = 1'b0;
    #1;
    check("r_valid",     64'(desc_valid), 64'(0));
    check("r_busy",      64'(busy),       64'(0));
    check("r_ram_en",    64'(ram_en),     64'(0));
    check("r_ram_addr",  64'(ram_addr),   64'(SA));
    check("r_patch_idx", 64'(patch_idx),  64'(0));
    check("r_last",      64'(desc_last),  64'(0));
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // A2: refetch patch 0 from START_ADDR, then B back-to-back
    desc_ready = 1'b1;
    expect_patch(0);
    pulse_start();
    wait_done(30);
    check("a2_patch_idx", 64'(patch_idx), 64'(1));

    // B: patch 1 under backpressure, spurious starts, frame finish
    desc_ready = 1'b0;
    expect_patch(1);
    en0 = en_cnt;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    pulse_start();  // during FETCH: ignored
    head = exp_q[0];
    check("b_valid",    64'(desc_valid), 64'(1));
    check("b_head_row", 64'(desc_row),   64'(head[DW-WW-1:0]));
    repeat (20) @(posedge clk);
    #1;
    check("b_issues",     64'(en_cnt - en0), 64'(2));
    check("b_valid_held", 64'(desc_valid),   64'(1));
    check("b_head_way",   64'(desc_way),     64'(head[DW-1 -: WW]));
    check("b_head_row2",  64'(desc_row),     64'(head[DW-WW-1:0]));
    check("b_patch_idx",  64'(patch_idx),    64'(1));
    desc_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pulse_start();  // during DRAIN: ignored
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (patch_done) break;
    end
    check("b_done_seen", 64'(patch_done), 64'(1));
    start = 1'b1;   // during DONE: ignored
    @(posedge clk); #1;
    start = 1'b0;
    check("b_patch_idx_wrap", 64'(patch_idx), 64'(0));
    check("b_frame_cnt",      64'(frame_cnt), 64'(1));
    en1 = en_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("b_no_refetch", 64'(en_cnt - en1), 64'(0));
    check("b_idle_busy",  64'(busy),         64'(0));
    check("b_done_total", 64'(done_cnt),     64'(3));
    check("sb_desc_empty", 64'(exp_q.size()),      64'(0));
    check("sb_addr_empty", 64'(exp_addr_q.size()), 64'(0));

`ifdef CWBP_WAY_CHECK_EN
    exp_we = 1'b1;
`else
    exp_we = 1'b0;
`endif
    check("way_err_final", 64'(way_err), 64'(exp_we));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
